// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared types and constants for the instruction sequencer.
// The sequencer only inspects the opcode nibble for HALT and, with SEQ_TRAP_EN
// defined, for the illegal range; everything else comes from the decoder.
package instr_sequencer_pkg;

   // Sequencer phases
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   // Opcode nibble values (instr[7:4])
   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_LOAD   = 4'h8;
   localparam logic [3:0] OP_STORE  = 4'h9;
   localparam logic [3:0] OP_ILL_LO = 4'hA;
   localparam logic [3:0] OP_ILL_HI = 4'hE;
   localparam logic [3:0] OP_HALT   = 4'hF;

   localparam int         PC_W_DEFAULT     = 8;
   localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

   // Per-cycle control strobes produced by the phase logic
   typedef struct packed {
      logic imem_req;
      logic dmem_req;
      logic dmem_we;
      logic rf_we;
      logic retire;
      logic pc_inc;
      logic set_halt;
   } seq_ctl_t;

   function automatic logic is_halt(input logic [7:0] ins);
      return ins[7:4] == OP_HALT;
   endfunction

   function automatic logic is_illegal(input logic [7:0] ins);
      return (ins[7:4] >= OP_ILL_LO) && (ins[7:4] <= OP_ILL_HI);
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-fetch and data-memory handshakes.
// master = sequencer side, slave = memory side. PC_W must match the sequencer.
interface instr_sequencer_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [7:0]      imem_rdata;
   logic            imem_ack;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_rdata, imem_ack, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_rdata, imem_ack, dmem_ack
   );
endinterface

// File: rtl/instr_sequencer_pc_reg.sv
// instr_sequencer_pc_reg: program counter, loads RESET_PC on reset and
// increments (wrapping modulo 2^PC_W) when i_inc is high.
module instr_sequencer_pc_reg #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_inc,
   output logic [PC_W-1:0] o_pc
);
   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   logic [PC_W-1:0] r_pc;

   // pc register: natural binary wrap on overflow
   always_ff @(posedge clk) begin
      if (reset)      r_pc <= RESET_PC;
      else if (i_inc) r_pc <= r_pc + PC_ONE;
   end

   assign o_pc = r_pc;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch / decode / execute / memory / writeback
// sequencer for the 8-bit-instruction core. Holds the instruction register,
// gates the decoder's reg_write and memory strobes so each fires once per
// instruction, and pulses o_retire on completion.
// Optional feature: define SEQ_TRAP_EN to treat opcodes 4'hA..4'hE as illegal
// (adds the sticky o_trap output); otherwise they run as NOPs.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_run,
   instr_sequencer_if.master bus,
   input  logic              i_dec_reg_write,
   input  logic              i_dec_mem_read,
   input  logic              i_dec_mem_write,
   output logic [7:0]        o_instr,
   output logic              o_rf_we,
   output logic [PC_W-1:0]   o_pc,
   output logic              o_retire,
   output logic              o_halted,
   output logic              o_busy
`ifdef SEQ_TRAP_EN
   ,
   output logic              o_trap
`endif
);

   state_t          r_state;
   state_t          w_next;
   seq_ctl_t        w_ctl;
   logic            w_done;
   logic [7:0]      r_instr;
   logic            r_halted;
   logic [PC_W-1:0] w_pc;
`ifdef SEQ_TRAP_EN
   logic            w_set_trap;
   logic            r_trap;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and strobe generation; strobes are forced low while in reset
   // so a handshake interrupted by reset never retires or writes anything.
   always_comb begin
      w_next = r_state;
      w_ctl  = '0;
      w_done = 1'b0;
`ifdef SEQ_TRAP_EN
      w_set_trap = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_run && !r_halted) w_next = S_FETCH;
         end
         S_FETCH: begin
            // address is pc itself, so it stays stable until ack
            w_ctl.imem_req = 1'b1;
            if (bus.imem_ack) w_next = S_DECODE;
         end
         S_DECODE: begin
            if (is_halt(r_instr)) begin
               // HALT retires but leaves pc pointing at itself
               w_ctl.set_halt = 1'b1;
               w_ctl.retire   = 1'b1;
               w_next         = S_IDLE;
            end
`ifdef SEQ_TRAP_EN
            else if (is_illegal(r_instr)) begin
               w_set_trap     = 1'b1;
               w_ctl.set_halt = 1'b1;
               w_next         = S_IDLE;
            end
`endif
            else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (i_dec_mem_read || i_dec_mem_write) w_next = S_MEM;
            else if (i_dec_reg_write)              w_next = S_WB;
            else                                   w_done = 1'b1;
         end
         S_MEM: begin
            // request held until ack; run dropping does not withdraw it
            w_ctl.dmem_req = 1'b1;
            w_ctl.dmem_we  = i_dec_mem_write;
            if (bus.dmem_ack) begin
               if (i_dec_reg_write) w_next = S_WB;
               else                 w_done = 1'b1;
            end
         end
         S_WB: begin
            w_ctl.rf_we = 1'b1;
            w_done      = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase

      if (w_done) begin
         w_ctl.retire = 1'b1;
         w_ctl.pc_inc = 1'b1;
         w_next       = i_run ? S_FETCH : S_IDLE;
      end

      if (reset) begin
         w_ctl = '0;
`ifdef SEQ_TRAP_EN
         w_set_trap = 1'b0;
`endif
      end
   end

   // Instruction register, captured on the fetch ack
   always_ff @(posedge clk) begin
      if (reset)                                  r_instr <= 8'h00;
      else if (r_state == S_FETCH && bus.imem_ack) r_instr <= bus.imem_rdata;
   end

   // Sticky halt flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)               r_halted <= 1'b0;
      else if (w_ctl.set_halt) r_halted <= 1'b1;
   end

`ifdef SEQ_TRAP_EN
   // Sticky trap flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)           r_trap <= 1'b0;
      else if (w_set_trap) r_trap <= 1'b1;
   end

   assign o_trap = r_trap;
`endif

   instr_sequencer_pc_reg #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_ctl.pc_inc),
      .o_pc  (w_pc)
   );

   assign bus.imem_req  = w_ctl.imem_req;
   assign bus.imem_addr = w_pc;
   assign bus.dmem_req  = w_ctl.dmem_req;
   assign bus.dmem_we   = w_ctl.dmem_we;
   assign o_instr       = r_instr;
   assign o_rf_we       = w_ctl.rf_we;
   assign o_pc          = w_pc;
   assign o_retire      = w_ctl.retire;
   assign o_halted      = r_halted;
   assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed programs against an instruction-level timing
// model (per-instruction latency from memory wait states and opcode class),
// checked every cycle, plus literal expectations per program.
`timescale 1ns/1ps
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   localparam int PC_W = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic       dec_rw, dec_mr, dec_mw;
   logic [7:0] instr;
   logic       rf_we, retire, halted, busy;
   logic [7:0] pc;
`ifdef SEQ_TRAP_EN
   logic       trap;
`endif

   instr_sequencer_if #(.PC_W(PC_W)) bus();

   instr_sequencer #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_run           (run),
      .bus             (bus),
      .i_dec_reg_write (dec_rw),
      .i_dec_mem_read  (dec_mr),
      .i_dec_mem_write (dec_mw),
      .o_instr         (instr),
      .o_rf_we         (rf_we),
      .o_pc            (pc),
      .o_retire        (retire),
      .o_halted        (halted),
      .o_busy          (busy)
`ifdef SEQ_TRAP_EN
      ,
      .o_trap          (trap)
`endif
   );

   always #5 clk = ~clk;

   // decoder stand-in
   always_comb begin
      dec_rw = (instr[7:4] == OP_ADD) || (instr[7:4] == OP_SUB) || (instr[7:4] == OP_LOAD);
      dec_mr = (instr[7:4] == OP_LOAD);
      dec_mw = (instr[7:4] == OP_STORE);
   end

   // memories with programmable wait states
   logic [7:0] imem [256];
   int imem_wait = 0, dmem_wait = 0;
   int icnt = 0, dcnt = 0;

   always_comb begin
      bus.imem_ack   = bus.imem_req && (icnt >= imem_wait);
      bus.imem_rdata = imem[bus.imem_addr];
      bus.dmem_ack   = bus.dmem_req && (dcnt >= dmem_wait);
   end

   always @(posedge clk) begin
      icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
      dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
   end

   int total = 0, bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // observation counters (cleared by apply_reset)
   int cyc = 0;
   int n_ret, n_rfwe, n_dreq, n_dwe, n_ireq, first_req, ret1_cyc, rfwe_cyc;

   // instruction-level model
   logic [7:0] m_pc = 8'h00, m_ins = 8'h00;
   logic       m_halted = 1'b0, m_trap = 1'b0, m_act = 1'b0;
   logic       m_rw, m_mem, m_st, m_halt, m_ill;
   int         m_t, m_lat, m_memlo, m_memhi;

   task automatic plan(input logic [7:0] ins);
      logic [3:0] op;
      op     = ins[7:4];
      m_ins  = ins;
      m_halt = (op == 4'hF);
`ifdef SEQ_TRAP_EN
      m_ill  = (op >= 4'hA) && (op <= 4'hE);
`else
      m_ill  = 1'b0;
`endif
      m_rw   = (op == 4'h0) || (op == 4'h1) || (op == 4'h8);
      m_mem  = (op == 4'h8) || (op == 4'h9);
      m_st   = (op == 4'h9);
      m_memlo = imem_wait + 3;
      m_memhi = imem_wait + 3 + dmem_wait;
      if (m_halt || m_ill) m_lat = imem_wait + 2;
      else m_lat = imem_wait + 3 + (m_mem ? dmem_wait + 1 : 0) + (m_rw ? 1 : 0);
      m_t   = 0;
      m_act = 1'b1;
   endtask

   // compare process: every cycle, mid-cycle
   initial begin
      logic e_ireq, e_dreq, e_last, e_ret, e_rfwe;
      forever begin
         @(negedge clk);
         cyc++;
         if (retire) begin n_ret++; if (ret1_cyc < 0) ret1_cyc = cyc; end
         if (rf_we) begin n_rfwe++; rfwe_cyc = cyc; end
         if (bus.dmem_req) n_dreq++;
         if (bus.dmem_req && bus.dmem_we) n_dwe++;
         if (bus.imem_req) begin n_ireq++; if (first_req < 0) first_req = cyc; end
         if (reset) begin
            chk("rst_imem_req", int'(bus.imem_req), 0);
            chk("rst_dmem_req", int'(bus.dmem_req), 0);
            chk("rst_rf_we",    int'(rf_we), 0);
            chk("rst_retire",   int'(retire), 0);
            m_pc = 8'h00; m_halted = 1'b0; m_trap = 1'b0; m_act = 1'b0;
         end else begin
            e_ireq = m_act && (m_t <= imem_wait);
            e_dreq = m_act && m_mem && (m_t >= m_memlo) && (m_t <= m_memhi);
            e_last = m_act && (m_t == m_lat - 1);
            e_ret  = e_last && !m_ill;
            e_rfwe = e_last && m_rw && !m_halt && !m_ill;
            chk("imem_req", int'(bus.imem_req), int'(e_ireq));
            chk("dmem_req", int'(bus.dmem_req), int'(e_dreq));
            chk("retire",   int'(retire), int'(e_ret));
            chk("rf_we",    int'(rf_we), int'(e_rfwe));
            chk("pc",       int'(pc), int'(m_pc));
            chk("halted",   int'(halted), int'(m_halted));
            chk("busy",     int'(busy), int'(m_act));
`ifdef SEQ_TRAP_EN
            chk("trap",     int'(trap), int'(m_trap));
`endif
            if (e_ireq) chk("imem_addr", int'(bus.imem_addr), int'(m_pc));
            if (e_dreq) chk("dmem_we", int'(bus.dmem_we), int'(m_st));
            if (m_act && m_t > imem_wait) chk("instr", int'(instr), int'(m_ins));
            if (!m_act) begin
               if (run && !m_halted) plan(imem[m_pc]);
            end else if (e_last) begin
               if (m_halt || m_ill) begin
                  m_halted = 1'b1;
                  m_trap   = m_trap | m_ill;
                  m_act    = 1'b0;
               end else begin
                  m_pc = m_pc + 8'h01;
                  if (run) plan(imem[m_pc]);
                  else     m_act = 1'b0;
               end
            end else begin
               m_t++;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) imem[i] = v;
   endtask

   task automatic apply_reset();
      run = 1'b0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      n_ret = 0; n_rfwe = 0; n_dreq = 0; n_dwe = 0; n_ireq = 0;
      first_req = -1; ret1_cyc = -1; rfwe_cyc = -1;
   endtask

   task automatic wait_halt(input string nm, input int budget);
      for (int k = 0; k < budget && !halted; k++) step(1);
      if (!halted) begin
         total++; bad++;
         $display("FAIL %s: halted got 0 expected 1 within %0d cycles", nm, budget);
      end
   endtask

   int guard;

   initial begin
      fill(8'h20);
      apply_reset();
      // reset state, and no fetch while run is low
      chk("rst_pc",     int'(pc), 0);
      chk("rst_instr",  int'(instr), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_busy",   int'(busy), 0);
      step(3);
      chk("idle_ireq",  n_ireq, 0);

      // ADD, HALT with zero-wait memory
      fill(8'h20); imem[0] = 8'h00; imem[1] = 8'hF0;
      apply_reset(); run = 1'b1;
      wait_halt("t1_halt", 30); step(3);
      chk("t1_pc",      int'(pc), 1);
      chk("t1_ret",     n_ret, 2);
      chk("t1_rfwe",    n_rfwe, 1);
      chk("t1_rfwe_at", rfwe_cyc - first_req, 3);
      chk("t1_ireq",    n_ireq, 2);

      // LOAD with data ack delayed 3 cycles
      fill(8'h20); imem[0] = 8'h80; imem[1] = 8'hF0; dmem_wait = 3;
      apply_reset(); run = 1'b1;
      wait_halt("t2_halt", 40); step(2);
      chk("t2_dreq",    n_dreq, 4);
      chk("t2_dwe",     n_dwe, 0);
      chk("t2_rfwe",    n_rfwe, 1);
      chk("t2_lat",     ret1_cyc - first_req, 7);
      chk("t2_pc",      int'(pc), 1);

      // STORE, zero wait: 4-cycle retire, no register write
      fill(8'h20); imem[0] = 8'h90; imem[1] = 8'hF0; dmem_wait = 0;
      apply_reset(); run = 1'b1;
      wait_halt("t3_halt", 30); step(2);
      chk("t3_dreq",    n_dreq, 1);
      chk("t3_dwe",     n_dwe, 1);
      chk("t3_rfwe",    n_rfwe, 0);
      chk("t3_lat",     ret1_cyc - first_req, 3);

      // mixed program with wait states on both sides
      fill(8'h20);
      imem[0] = 8'h10; imem[1] = 8'h80; imem[2] = 8'h90; imem[3] = 8'h30; imem[4] = 8'hF0;
      imem_wait = 2; dmem_wait = 1;
      apply_reset(); run = 1'b1;
      wait_halt("t4_halt", 80); step(2);
      chk("t4_ret",     n_ret, 5);
      chk("t4_rfwe",    n_rfwe, 2);
      chk("t4_dreq",    n_dreq, 4);
      chk("t4_pc",      int'(pc), 4);

      // pc wrap: NOPs up to 8'hFE, ADD at 8'hFF, stop after it
      fill(8'h20); imem[255] = 8'h00; imem_wait = 1; dmem_wait = 0;
      apply_reset(); run = 1'b1;
      guard = 0;
      while (guard < 2000 && pc != 8'hFF) begin step(1); guard++; end
      chk("t5_reach_ff", int'(pc), 255);
      run = 1'b0;
      step(10);
      chk("t5_pc",      int'(pc), 0);
      chk("t5_ret",     n_ret, 256);
      chk("t5_rfwe",    n_rfwe, 1);
      chk("t5_busy",    int'(busy), 0);

      // run dropped while a LOAD waits on its data ack
      fill(8'h20); imem[0] = 8'h80; imem[1] = 8'h00; imem_wait = 0; dmem_wait = 4;
      apply_reset(); run = 1'b1;
      guard = 0;
      while (guard < 20 && !bus.dmem_req) begin step(1); guard++; end
      chk("t6_in_mem",  int'(bus.dmem_req), 1);
      run = 1'b0;
      step(15);
      chk("t6_dreq",    n_dreq, 5);
      chk("t6_ret",     n_ret, 1);
      chk("t6_ireq",    n_ireq, 1);
      chk("t6_pc",      int'(pc), 1);
      chk("t6_busy",    int'(busy), 0);

      // reset while a fetch is waiting for its ack
      fill(8'h20); imem_wait = 5; dmem_wait = 0;
      apply_reset(); run = 1'b1;
      guard = 0;
      while (guard < 100 && !(pc == 8'h01 && bus.imem_req)) begin step(1); guard++; end
      chk("t7_fetch1",  int'(pc), 1);
      step(1);
      reset = 1'b1;
      step(1);
      chk("t7_ireq",    int'(bus.imem_req), 0);
      chk("t7_pc",      int'(pc), 0);
      chk("t7_ret",     n_ret, 1);
      chk("t7_busy",    int'(busy), 0);
      reset = 1'b0; run = 1'b0;
      step(2);

      // opcode 8'hA0: trap when enabled, NOP otherwise
      fill(8'h20); imem[0] = 8'hA0; imem[1] = 8'hF0; imem_wait = 0;
      apply_reset(); run = 1'b1;
      wait_halt("t8_halt", 30); step(2);
`ifdef SEQ_TRAP_EN
      chk("t8_trap",    int'(trap), 1);
      chk("t8_pc",      int'(pc), 0);
      chk("t8_ret",     n_ret, 0);
`else
      chk("t8_pc",      int'(pc), 1);
      chk("t8_ret",     n_ret, 2);
      chk("t8_rfwe",    n_rfwe, 0);
`endif

      apply_reset();
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
